// File: rtl/soc_system_onchip_arb_pkg.sv
// Shared types and defaults for the on-chip RAM arbiter.
// Requester ids, bus widths, RAM depth and the out-of-range read pattern.
package soc_system_onchip_arb_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_BE_W   = 4;
  localparam int DEF_DEPTH  = 40000;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

  function automatic req_id_t other_req(
    input req_id_t id
  );
    return (id == REQ_A) ? REQ_B : REQ_A;
  endfunction

endpackage

// File: rtl/soc_system_rr_arb2.sv
// Two-way round-robin arbiter with its last_grant register.
// Ports: clk, reset, en (issue allowed), req_a, req_b -> gnt_valid, gnt.
module soc_system_rr_arb2
  import soc_system_onchip_arb_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    en,
  input  logic    req_a,
  input  logic    req_b,
  output logic    gnt_valid,
  output req_id_t gnt
);

  req_id_t last_grant;

  always_comb begin
    gnt = REQ_A;
    unique case (1'b1)
      (req_a && req_b):  gnt = other_req(last_grant);
      (req_a && !req_b): gnt = REQ_A;
      (!req_a && req_b): gnt = REQ_B;
      default:           gnt = REQ_A;
    endcase
    gnt_valid = en && (req_a || req_b);
  end

  // Starting at B lets A win the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= REQ_B;
    end else if (gnt_valid) begin
      last_grant <= gnt;
    end
  end

endmodule

// File: rtl/soc_system_onchip_mem_arbiter.sv
// Shares the single-port on-chip RAM between Avalon-MM requesters A and B.
// Ports: clk/reset, a_*/b_* slave sides, mem_* RAM master side.
// Define ONCHIP_ARB_BOUNDS_CHECK_EN to add address bounds checking
// and the err_count output.
module soc_system_onchip_mem_arbiter
  import soc_system_onchip_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int BE_W   = DEF_BE_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] a_address,
  input  logic [BE_W-1:0]   a_byteenable,
  input  logic              a_read,
  input  logic              a_write,
  input  logic [DATA_W-1:0] a_writedata,
  output logic              a_waitrequest,
  output logic [DATA_W-1:0] a_readdata,
  output logic              a_readdatavalid,
  input  logic [ADDR_W-1:0] b_address,
  input  logic [BE_W-1:0]   b_byteenable,
  input  logic              b_read,
  input  logic              b_write,
  input  logic [DATA_W-1:0] b_writedata,
  output logic              b_waitrequest,
  output logic [DATA_W-1:0] b_readdata,
  output logic              b_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
`ifdef ONCHIP_ARB_BOUNDS_CHECK_EN
  ,
  output logic [15:0]       err_count
`endif
);

  logic    issue;
  req_id_t win;

  logic [ADDR_W-1:0] w_addr;
  logic [BE_W-1:0]   w_be;
  logic [DATA_W-1:0] w_wdata;
  logic              w_wr;
  logic              w_rd;
  logic              oob;

  logic              rd_pend;
  req_id_t           rd_id;
  logic              rd_err;
  logic [DATA_W-1:0] rd_data;

  // No command is accepted while reset is held.
  soc_system_rr_arb2 u_arb (
    .clk       (clk),
    .reset     (reset),
    .en        (!reset),
    .req_a     (a_read || a_write),
    .req_b     (b_read || b_write),
    .gnt_valid (issue),
    .gnt       (win)
  );

  // Winner mux; a read together with a write counts as a write.
  always_comb begin
    w_addr  = a_address;
    w_be    = a_byteenable;
    w_wdata = a_writedata;
    w_wr    = a_write;
    w_rd    = a_read && !a_write;
    if (win == REQ_B) begin
      w_addr  = b_address;
      w_be    = b_byteenable;
      w_wdata = b_writedata;
      w_wr    = b_write;
      w_rd    = b_read && !b_write;
    end
  end

`ifdef ONCHIP_ARB_BOUNDS_CHECK_EN
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  assign oob = ({1'b0, w_addr} >= DEPTH_L);
`else
  assign oob = 1'b0;
`endif

  // Out-of-range commands are accepted but never reach the RAM.
  assign a_waitrequest  = !(issue && (win == REQ_A));
  assign b_waitrequest  = !(issue && (win == REQ_B));
  assign mem_address    = w_addr;
  assign mem_byteenable = w_be;
  assign mem_writedata  = w_wdata;
  assign mem_chipselect = issue && !oob;
  assign mem_write      = issue && w_wr && !oob;
  assign mem_clken      = 1'b1;

  assign rd_data = rd_err ? DATA_W'(ERR_DATA) : mem_readdata;

  // Stage 1 tracks the read in flight while the RAM looks it up;
  // stage 2 registers the returned word toward its requester.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pend         <= 1'b0;
      rd_id           <= REQ_A;
      rd_err          <= 1'b0;
      a_readdatavalid <= 1'b0;
      b_readdatavalid <= 1'b0;
      a_readdata      <= '0;
      b_readdata      <= '0;
    end else begin
      rd_pend         <= issue && w_rd;
      rd_id           <= win;
      rd_err          <= oob;
      a_readdatavalid <= rd_pend && (rd_id == REQ_A);
      b_readdatavalid <= rd_pend && (rd_id == REQ_B);
      if (rd_pend && (rd_id == REQ_A)) begin
        a_readdata <= rd_data;
      end
      if (rd_pend && (rd_id == REQ_B)) begin
        b_readdata <= rd_data;
      end
    end
  end

`ifdef ONCHIP_ARB_BOUNDS_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      err_count <= '0;
    end else if (issue && oob && (err_count != 16'hFFFF)) begin
      err_count <= err_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_soc_system_onchip_mem_arbiter.sv
// Directed bench for soc_system_onchip_mem_arbiter with a 1-cycle RAM model.
// Inputs change 1ns after posedge; outputs are checked at negedge.
module tb_soc_system_onchip_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] a_address, b_address;
  logic [3:0]  a_byteenable, b_byteenable;
  logic        a_read, a_write, b_read, b_write;
  logic [31:0] a_writedata, b_writedata;
  logic        a_waitrequest, b_waitrequest;
  logic [31:0] a_readdata, b_readdata;
  logic        a_readdatavalid, b_readdatavalid;
  logic [15:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
`ifdef ONCHIP_ARB_BOUNDS_CHECK_EN
  logic [15:0] err_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  soc_system_onchip_mem_arbiter dut (
    .clk             (clk),
    .reset           (reset),
    .a_address       (a_address),
    .a_byteenable    (a_byteenable),
    .a_read          (a_read),
    .a_write         (a_write),
    .a_writedata     (a_writedata),
    .a_waitrequest   (a_waitrequest),
    .a_readdata      (a_readdata),
    .a_readdatavalid (a_readdatavalid),
    .b_address       (b_address),
    .b_byteenable    (b_byteenable),
    .b_read          (b_read),
    .b_write         (b_write),
    .b_writedata     (b_writedata),
    .b_waitrequest   (b_waitrequest),
    .b_readdata      (b_readdata),
    .b_readdatavalid (b_readdatavalid),
    .mem_address     (mem_address),
    .mem_byteenable  (mem_byteenable),
    .mem_chipselect  (mem_chipselect),
    .mem_write       (mem_write),
    .mem_writedata   (mem_writedata),
    .mem_clken       (mem_clken),
    .mem_readdata    (mem_readdata)
`ifdef ONCHIP_ARB_BOUNDS_CHECK_EN
    ,
    .err_count       (err_count)
`endif
  );

  // RAM model: byte-enabled writes, registered reads, bench preload port.
  logic [31:0] ram [0:65535];
  logic        ld_en;
  logic [15:0] ld_addr;
  logic [31:0] ld_data;

  always @(posedge clk) begin
    if (ld_en) begin
      ram[ld_addr] <= ld_data;
    end else if (mem_chipselect) begin
      if (mem_write) begin
        for (int i = 0; i < 4; i++) begin
          if (mem_byteenable[i]) begin
            ram[mem_address][8*i +: 8] <= mem_writedata[8*i +: 8];
          end
        end
      end else begin
        mem_readdata <= ram[mem_address];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    a_read = 0; a_write = 0; b_read = 0; b_write = 0;
    a_byteenable = 4'hF; b_byteenable = 4'hF;
    a_writedata = '0; b_writedata = '0;
  endtask

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] ad, input logic [31:0] d);
    ld_en = 1; ld_addr = ad; ld_data = d;
    drive_edge();
    ld_en = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    idle();
    drive_edge();
    drive_edge();
  endtask

  initial begin
    reset = 1; ld_en = 0; ld_addr = '0; ld_data = '0;
    a_address = '0; b_address = '0;
    idle();
    drive_edge();
    load(16'h0010, 32'h1234_5678);
    load(16'h0100, 32'h0000_0000);
    for (int i = 0; i < 4; i++) load(16'(i), 32'hC0DE_0000 + i);
    @(negedge clk);
    check("rst a_wait", a_waitrequest, 1);
    check("rst b_wait", b_waitrequest, 1);
    check("rst a_rdv", a_readdatavalid, 0);
    check("rst b_rdv", b_readdatavalid, 0);
    check("rst a_rd", a_readdata, 0);
    check("rst b_rd", b_readdata, 0);
    check("rst cs", mem_chipselect, 0);
    check("rst mwr", mem_write, 0);
    check("clken", mem_clken, 1);
`ifdef ONCHIP_ARB_BOUNDS_CHECK_EN
    check("rst errcnt", err_count, 0);
`endif

    // A single read of 0x10
    drive_edge();
    reset = 0; a_read = 1; a_address = 16'h0010;
    @(negedge clk);
    check("t1 a_wait", a_waitrequest, 0);
    check("t1 b_wait", b_waitrequest, 1);
    check("t1 cs", mem_chipselect, 1);
    check("t1 mwr", mem_write, 0);
    check("t1 maddr", mem_address, 16'h0010);
    drive_edge();
    a_read = 0;
    @(negedge clk);
    check("t1 n+1 rdv", a_readdatavalid, 0);
    check("t1 n+1 cs", mem_chipselect, 0);
    drive_edge();
    @(negedge clk);
    check("t1 n+2 rdv", a_readdatavalid, 1);
    check("t1 n+2 rd", a_readdata, 32'h1234_5678);
    check("t1 n+2 brdv", b_readdatavalid, 0);
    drive_edge();
    @(negedge clk);
    check("t1 n+3 rdv", a_readdatavalid, 0);
    check("t1 hold rd", a_readdata, 32'h1234_5678);

    // Both request every cycle: A,B,A,B,...
    do_reset();
    for (int i = 0; i < 8; i++) begin
      reset = 0; a_read = 1; b_read = 1;
      a_address = 16'h0020; b_address = 16'h0021;
      @(negedge clk);
      check($sformatf("rr%0d a_wait", i), a_waitrequest, (i % 2 == 1));
      check($sformatf("rr%0d b_wait", i), b_waitrequest, (i % 2 == 0));
      drive_edge();
    end
    idle();
    drive_edge();
    drive_edge();

    // B partial write then readback
    b_write = 1; b_address = 16'h0100;
    b_writedata = 32'hAABB_CCDD; b_byteenable = 4'b0101;
    @(negedge clk);
    check("t3 b_wait", b_waitrequest, 0);
    check("t3 mwr", mem_write, 1);
    check("t3 mbe", mem_byteenable, 4'b0101);
    drive_edge();
    b_write = 0; b_read = 1; b_byteenable = 4'hF;
    @(negedge clk);
    check("t3 rd mwr", mem_write, 0);
    drive_edge();
    b_read = 0;
    @(negedge clk);
    drive_edge();
    @(negedge clk);
    check("t3 b_rdv", b_readdatavalid, 1);
    check("t3 b_rd", b_readdata, 32'h00BB_00DD);
    check("t3 a_rdv", a_readdatavalid, 0);

    // read+write together is a write with no response
    drive_edge();
    a_read = 1; a_write = 1; a_address = 16'h0200;
    @(negedge clk);
    check("rw mwr", mem_write, 1);
    drive_edge();
    idle();
    @(negedge clk);
    drive_edge();
    @(negedge clk);
    check("rw no rdv", a_readdatavalid, 0);

    // 4 back-to-back A reads
    for (int k = 0; k < 6; k++) begin
      drive_edge();
      a_read = (k < 4); a_address = 16'(k);
      @(negedge clk);
      check($sformatf("b2b%0d rdv", k), a_readdatavalid, (k >= 2));
      if (k >= 2) begin
        check($sformatf("b2b%0d rd", k), a_readdata, 32'hC0DE_0000 + k - 2);
      end
    end

    // reset the cycle after a read issue drops the response
    drive_edge();
    a_read = 1; a_address = 16'h0010;
    @(negedge clk);
    check("t5 a_wait", a_waitrequest, 0);
    drive_edge();
    a_read = 0; reset = 1;
    @(negedge clk);
    drive_edge();
    reset = 0;
    @(negedge clk);
    check("t5 a_rdv", a_readdatavalid, 0);
    check("t5 a_rd", a_readdata, 0);
    check("t5 a_wait", a_waitrequest, 1);
    check("t5 b_wait", b_waitrequest, 1);
    check("t5 cs", mem_chipselect, 0);
    drive_edge();
    @(negedge clk);
    check("t5 late rdv", a_readdatavalid, 0);

`ifdef ONCHIP_ARB_BOUNDS_CHECK_EN
    drive_edge();
    a_read = 1; a_address = 16'd40000;
    @(negedge clk);
    check("oob a_wait", a_waitrequest, 0);
    check("oob cs", mem_chipselect, 0);
    drive_edge();
    a_read = 0;
    @(negedge clk);
    check("oob errcnt", err_count, 1);
    drive_edge();
    @(negedge clk);
    check("oob rdv", a_readdatavalid, 1);
    check("oob rd", a_readdata, 32'hDEAD_BEEF);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
